// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared UART types and helpers for the RX and TX paths.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Rounded to the nearest whole clock.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module   : sync_2ff
// Brief    : Two-flop synchroniser for asynchronous inputs, with selectable reset value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module   : uart_rx
// Brief    : 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready
//            output buffer. Define UART_RX_PARITY_EN for 8E1 with o_parity_err.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 64_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    output logic       o_busy
);

    localparam int              CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int              c_CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF    = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(CLKS_PER_BIT - 1);

    logic               rx_s;
    logic               rx_q;
    uart_state_e        state_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [2:0]         idx_q;
    logic [7:0]         shift_q;
    logic [7:0]         data_q;
    logic               valid_q;
    logic               frame_err_q;
    logic               overrun_q;
    logic               sample_d;
    logic               stop_hit_d;
    logic               frame_err_d;
    logic               done_d;
`ifdef UART_RX_PARITY_EN
    logic               par_q;
    logic               parity_err_q;
    logic               parity_err_d;
`endif

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_rx),
        .o_q (rx_s)
    );

    always_comb begin
        sample_d    = (cnt_q == '0);
        stop_hit_d  = (state_q == STOP) && sample_d;
        frame_err_d = stop_hit_d && !rx_s;
`ifdef UART_RX_PARITY_EN
        // A bad stop bit wins over a parity mismatch.
        parity_err_d = stop_hit_d && rx_s && (^{shift_q, par_q});
        done_d       = stop_hit_d && rx_s && !(^{shift_q, par_q});
`else
        done_d       = stop_hit_d && rx_s;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q        <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_q        <= rx_s;
            frame_err_q <= frame_err_d;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
            case (state_q)
                IDLE: begin
                    if (rx_q && !rx_s) begin
                        cnt_q   <= c_HALF;
                        state_q <= START;
                    end
                end
                START: begin
                    if (sample_d) begin
                        if (!rx_s) begin
                            cnt_q   <= c_FULL;
                            idx_q   <= '0;
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (sample_d) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= c_FULL;
                        if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_d) begin
                        par_q   <= rx_s;
                        cnt_q   <= c_FULL;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (sample_d) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A completion coinciding with a handshake refills the buffer.
            if (done_d) begin
                if (!valid_q || i_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
    assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx at 8 clocks per bit.
//            Honours UART_RX_PARITY_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_rx = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;
    logic       o_parity_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] acc_q[$];
    int n_vhi = 0, n_frm = 0, n_ovr = 0, n_par = 0, n_both = 0;
    logic busy_mid;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_HZ (64_000_000),
        .BAUD   (8_000_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (o_parity_err),
`endif
        .o_busy       (o_busy)
    );

`ifndef UART_RX_PARITY_EN
    assign o_parity_err = 1'b0;
`endif

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid && i_ready) acc_q.push_back(o_data);
            if (o_valid) n_vhi++;
            if (o_frame_err) n_frm++;
            if (o_overrun) n_ovr++;
            if (o_parity_err) n_par++;
            if (o_frame_err && o_overrun) n_both++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic v, input int n);
        i_rx = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b, input int gap);
        drive(1'b0, CPB);
        busy_mid = o_busy;
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive(par_b, CPB);
`endif
        drive(stop_b, CPB);
        drive(1'b1, gap);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({o_data, o_valid, o_frame_err, o_overrun, o_busy, o_parity_err} !== 13'h0) begin
            bad++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b pe=%b want all 0",
                     o_data, o_valid, o_frame_err, o_overrun, o_busy, o_parity_err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 5);
    endtask

    task automatic test_basic();
        int a0, v0, f0, o0;
        i_ready = 1'b1;
        a0 = acc_q.size(); v0 = n_vhi; f0 = n_frm; o0 = n_ovr;
        send_frame(8'h55, 1'b1, ^8'h55, 20);
        total++;
        if (busy_mid !== 1'b1) begin bad++; $display("FAIL basic_busy_mid: got %b want 1", busy_mid); end
        total++;
        if (acc_q.size() - a0 != 1 || acc_q[acc_q.size()-1] !== 8'h55) begin
            bad++; $display("FAIL basic_data: got count=%0d last=%h want count=1 data=55",
                            acc_q.size() - a0, acc_q.size() ? acc_q[acc_q.size()-1] : 8'h0);
        end
        total++;
        if (n_vhi - v0 != 1) begin bad++; $display("FAIL basic_valid_width: got %0d cycles want 1", n_vhi - v0); end
        total++;
        if (n_frm != f0 || n_ovr != o0) begin
            bad++; $display("FAIL basic_flags: got fe=%0d ov=%0d want 0 0", n_frm - f0, n_ovr - o0);
        end
        total++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            bad++; $display("FAIL basic_idle: got busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        int a0, o0;
        i_ready = 1'b0;
        a0 = acc_q.size(); o0 = n_ovr;
        send_frame(8'hA3, 1'b1, ^8'hA3, 0);
        send_frame(8'h0F, 1'b1, ^8'h0F, 20);
        total++;
        if (o_valid !== 1'b1 || o_data !== 8'hA3) begin
            bad++; $display("FAIL b2b_retain: got v=%b data=%h want v=1 data=a3", o_valid, o_data);
        end
        total++;
        if (n_ovr - o0 != 1) begin bad++; $display("FAIL b2b_overrun: got %0d pulses want 1", n_ovr - o0); end
        i_ready = 1'b1;
        drive(1'b1, 3);
        total++;
        if (o_valid !== 1'b0 || acc_q.size() - a0 != 1 || acc_q[acc_q.size()-1] !== 8'hA3) begin
            bad++; $display("FAIL b2b_drain: got v=%b count=%0d want v=0 count=1 data=a3",
                            o_valid, acc_q.size() - a0);
        end
    endtask

    task automatic test_frame_err();
        int a0, f0, o0, b0;
        i_ready = 1'b1;
        a0 = acc_q.size(); f0 = n_frm; o0 = n_ovr; b0 = n_both;
        send_frame(8'h3C, 1'b0, ^8'h3C, 20);
        total++;
        if (n_frm - f0 != 1) begin bad++; $display("FAIL ferr_pulse: got %0d cycles want 1", n_frm - f0); end
        total++;
        if (acc_q.size() != a0 || o_valid !== 1'b0) begin
            bad++; $display("FAIL ferr_discard: got count=%0d v=%b want 0 0", acc_q.size() - a0, o_valid);
        end
        send_frame(8'h81, 1'b1, ^8'h81, 20);
        total++;
        if (acc_q.size() - a0 != 1 || acc_q[acc_q.size()-1] !== 8'h81 || n_frm - f0 != 1) begin
            bad++; $display("FAIL ferr_recover: got count=%0d fe=%0d want count=1 data=81 fe=1",
                            acc_q.size() - a0, n_frm - f0);
        end
        total++;
        if (n_both != b0 || n_ovr != o0) begin
            bad++; $display("FAIL ferr_exclusive: got both=%0d ov=%0d want 0 0", n_both - b0, n_ovr - o0);
        end
    endtask

    task automatic test_glitch();
        int a0, v0, f0, o0;
        a0 = acc_q.size(); v0 = n_vhi; f0 = n_frm; o0 = n_ovr;
        drive(1'b0, 3);
        drive(1'b1, 30);
        total++;
        if (o_busy !== 1'b0 || acc_q.size() != a0 || n_vhi != v0 || n_frm != f0 || n_ovr != o0) begin
            bad++; $display("FAIL glitch: got busy=%b bytes=%0d fe=%0d ov=%0d want all 0",
                            o_busy, acc_q.size() - a0, n_frm - f0, n_ovr - o0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int a0;
        i_ready = 1'b1;
        a0 = acc_q.size();
        drive(1'b0, CPB);
        drive(1'b1, 4 * CPB + 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({o_data, o_valid, o_frame_err, o_overrun, o_busy} !== 12'h0) begin
            bad++; $display("FAIL midrst_outputs: got data=%h v=%b fe=%b ov=%b busy=%b want all 0",
                            o_data, o_valid, o_frame_err, o_overrun, o_busy);
        end
        drive(1'b1, 5 * CPB);
        total++;
        if (acc_q.size() != a0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL midrst_abort: got bytes=%0d busy=%b want 0 0", acc_q.size() - a0, o_busy);
        end
        send_frame(8'h12, 1'b1, ^8'h12, 20);
        total++;
        if (acc_q.size() - a0 != 1 || acc_q[acc_q.size()-1] !== 8'h12) begin
            bad++; $display("FAIL midrst_next: got count=%0d want count=1 data=12", acc_q.size() - a0);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int a0, p0;
        i_ready = 1'b1;
        a0 = acc_q.size(); p0 = n_par;
        send_frame(8'h07, 1'b1, 1'b1, 20);
        total++;
        if (acc_q.size() - a0 != 1 || acc_q[acc_q.size()-1] !== 8'h07 || n_par != p0) begin
            bad++; $display("FAIL parity_good: got count=%0d pe=%0d want count=1 pe=0",
                            acc_q.size() - a0, n_par - p0);
        end
        send_frame(8'h07, 1'b1, 1'b0, 20);
        total++;
        if (n_par - p0 != 1 || acc_q.size() - a0 != 1 || o_valid !== 1'b0) begin
            bad++; $display("FAIL parity_bad: got pe=%0d count=%0d v=%b want pe=1 count=1 v=0",
                            n_par - p0, acc_q.size() - a0, o_valid);
        end
    endtask
`endif

    // Reference: a one-entry mailbox fed by well-formed frames and drained when ready.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic       m_valid;
        logic [7:0] m_data;
        int a0, f0, o0, p0;
        int e_frm, e_ovr, e_par;
        logic [7:0] b;
        logic stop_b, par_b, r;
        m_valid = 1'b0; m_data = 8'h0;
        e_frm = 0; e_ovr = 0; e_par = 0;
        a0 = acc_q.size(); f0 = n_frm; o0 = n_ovr; p0 = n_par;
        for (int k = 0; k < 12; k++) begin
            b      = 8'($urandom_range(0, 255));
            stop_b = ($urandom_range(0, 3) != 0);
            par_b  = (^b) ^ ($urandom_range(0, 3) == 0);
            r      = 1'($urandom_range(0, 1));
            i_ready = r;
            if (r && m_valid) begin
                exp_q.push_back(m_data);
                m_valid = 1'b0;
            end
            send_frame(b, stop_b, par_b, 12);
            if (!stop_b) begin
                e_frm++;
`ifdef UART_RX_PARITY_EN
            end else if ((^b) ^ par_b) begin
                e_par++;
`endif
            end else if (r) begin
                exp_q.push_back(b);
            end else if (m_valid) begin
                e_ovr++;
            end else begin
                m_valid = 1'b1;
                m_data  = b;
            end
        end
        i_ready = 1'b1;
        if (m_valid) exp_q.push_back(m_data);
        drive(1'b1, 4);
        total++;
        if (acc_q.size() - a0 != exp_q.size()) begin
            bad++; $display("FAIL rand_count: got %0d bytes want %0d", acc_q.size() - a0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (acc_q[a0 + i] !== exp_q[i]) begin
                    bad++; $display("FAIL rand_byte%0d: got %h want %h", i, acc_q[a0 + i], exp_q[i]);
                end
            end
        end
        total++;
        if (n_frm - f0 != e_frm || n_ovr - o0 != e_ovr || n_par - p0 != e_par) begin
            bad++; $display("FAIL rand_flags: got fe=%0d ov=%0d pe=%0d want fe=%0d ov=%0d pe=%0d",
                            n_frm - f0, n_ovr - o0, n_par - p0, e_frm, e_ovr, e_par);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the tinyQV FPGA build.
- Serves the RX direction of the same link whose TX leaves the core on UART_TXD.
- Synchronises the asynchronous UART_RXD pin and recovers bytes by mid-bit sampling.
- Presents each byte on a valid/ready interface for the CPU peripheral bus, with framing-error and overrun flags.

Parameters:
- CLK_HZ, 64_000_000, core clock frequency (the rPLL output).
- BAUD, 115_200, line rate.
- CLKS_PER_BIT, (CLK_HZ+BAUD/2)/BAUD = 556, clocks per bit, derived (localparam); must be >= 4.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- i_rx  in  1  asynchronous serial input, idle high
- o_data  out  8  received byte, LSB first on the wire
- o_valid  out  1  o_data holds an unconsumed byte
- i_ready  in  1  consumer accepts; transfer occurs when o_valid && i_ready
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: byte lost because the previous byte was unconsumed
- o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, FSM=IDLE, synchroniser flops=1.
- Reset mid-frame aborts the frame with no flags.
- Synchroniser: 2 flops, so rx_s lags i_rx by 2 cycles. A third flop, rx_q, is used for edge detection.
- Counter: bit_cnt down-counter, width $clog2(CLKS_PER_BIT).
- IDLE: on rx_q=1 && rx_s=0 (falling edge), load bit_cnt=CLKS_PER_BIT/2-1 and go to START. A line held low never retriggers.
- START: decrement; at 0 sample rx_s.
  - rx_s=0: load CLKS_PER_BIT-1, clear bit index, go to DATA.
  - rx_s=1: treat as a glitch and return to IDLE with no flag.
- DATA: at each bit_cnt=0, shift rx_s into shift[7] (right shift) and reload the counter. After the 8th sample go to STOP (or PARITY, see Optional Feature).
- STOP: at bit_cnt=0 sample rx_s, then go to IDLE in the same transition.
  - rx_s=1: byte complete.
  - rx_s=0: o_frame_err=1 for the next cycle; byte discarded; o_valid unaffected.
- Byte-complete latency: o_data/o_valid update on the cycle after the mid-stop sample. Total ≈ 9.5 bit times + 3 cycles after the start edge.
- Output buffer (one entry):
  - On completion with o_valid=0: load o_data, set o_valid.
  - On completion with o_valid=1 && !i_ready: drop the new byte, keep the old one, pulse o_overrun for 1 cycle.
  - On completion in the same cycle as a handshake: load the new byte, o_valid stays 1, no overrun.
  - A handshake without completion clears o_valid. o_data holds its value after the handshake.
- o_frame_err and o_overrun never assert in the same cycle: stop low means no completion.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1. After DATA, the FSM enters PARITY and samples one extra bit at mid-bit.
  - If data XOR parity bit is 1, the byte is discarded (treated like a framing error).
  - Adds output o_parity_err (1-cycle pulse, reset 0), asserted the cycle after the stop sample, instead of delivering the byte.
  - A bad stop bit takes precedence: o_frame_err only.
- Undefined: 8N1 only; no PARITY state; no o_parity_err port.

Decomposition:
- uart_pkg contents:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - function clks_per_bit(clk_hz, baud).
  - localparam DATA_BITS=8.
  - Shared with the existing TX path.
- One sub-module: sync_2ff (parameterised reset value 1), reusable for button inputs s1/s2.

Test Plan (CLK_HZ=64_000_000, BAUD=8_000_000 → CLKS_PER_BIT=8):
- Send 0x55, i_ready=1 → o_valid pulses 1 cycle with o_data=0x55; no error flags; o_busy low afterwards.
- Send 0xA3 then 0x0F back-to-back with i_ready=0 → o_data=0xA3 retained, o_overrun pulses once at the second stop sample; then i_ready=1 → o_valid drops.
- Send 0x3C with stop bit forced 0 → o_frame_err pulses 1 cycle; o_valid stays 0; with the line then raised, the next 0x81 is received correctly.
- 3-cycle low glitch on idle line → FSM returns to IDLE; no o_valid and no flags.
- Assert rst for 1 cycle during DATA bit 4 of 0xFF → all outputs 0, o_busy=0; the next 0x12 is received intact.
- UART_RX_PARITY_EN: send 0x07 with even parity 1 → delivered; with parity 0 → o_parity_err pulses, o_valid stays 0.
